bcd_conversion_arbiter: RTL and testbench

- Shares one binary_to_BCD_converter instance among N_REQ requesters, e.g. several Fibonacci/display channels that each need a binary-to-BCD result.
- Each requester holds a level request. The arbiter picks one requester by round-robin, drives the converter's start and binary input, and captures the BCD result.
- It then returns the result to the winning requester with a one-cycle done pulse.
- A watchdog aborts a transaction if the converter never signals done.

---
 rtl/bcd_conversion_arbiter_if.sv | 50 +++++
 rtl/bcd_conversion_arbiter.sv | 134 +++++++++++++
 tb/tb_bcd_conversion_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_conversion_arbiter_if.sv
// Requester-side and converter-side signals of bcd_conversion_arbiter.
// master is the arbiter's view; slave is the view of whatever surrounds it.
interface bcd_conversion_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 14,
    parameter int unsigned BCD_W = 16
);
    logic [N_REQ-1:0]   req_i;
    logic [N_REQ*W-1:0] bin_i;
    logic [N_REQ-1:0]   grant_o;
    logic [N_REQ-1:0]   done_o;
    logic [BCD_W-1:0]   bcd_o;
    logic               err_o;
    logic               busy_o;
    logic               conv_start_o;
    logic [W-1:0]       conv_bin_o;
    logic               conv_ready_i;
    logic               conv_done_i;
    logic [BCD_W-1:0]   conv_bcd_i;

    modport master (
        input  req_i,
        input  bin_i,
        input  conv_ready_i,
        input  conv_done_i,
        input  conv_bcd_i,
        output grant_o,
        output done_o,
        output bcd_o,
        output err_o,
        output busy_o,
        output conv_start_o,
        output conv_bin_o
    );

    modport slave (
        output req_i,
        output bin_i,
        output conv_ready_i,
        output conv_done_i,
        output conv_bcd_i,
        input  grant_o,
        input  done_o,
        input  bcd_o,
        input  err_o,
        input  busy_o,
        input  conv_start_o,
        input  conv_bin_o
    );
endinterface

// File: rtl/bcd_conversion_arbiter.sv
// Round-robin sharing of one binary-to-BCD converter among N_REQ requesters,
// with a watchdog that aborts a conversion whose done pulse never arrives.
module bcd_conversion_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned W       = 14,
    parameter int unsigned BCD_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input logic                      clk_i,
    input logic                      reset_ni,
    bcd_conversion_arbiter_if.master bus_if
);
    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] OneHotBase = N_REQ'(1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRespond
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [W-1:0]      opnd_q, opnd_d;
    logic [BCD_W-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic [TmrW-1:0]   timer_q, timer_d;

    logic [W-1:0]      opnd_arr [N_REQ];
    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   cand_idx;
    int unsigned       scan_k;
    logic [N_REQ-1:0]  owner_oh;

    for (genvar g = 0; g < N_REQ; g++) begin : g_opnd
        assign opnd_arr[g] = bus_if.bin_i[g*W +: W];
    end

    // First requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand_idx  = '0;
        scan_k    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_k = 32'(rr_ptr_q) + i;
            if (scan_k >= N_REQ) begin
                scan_k = scan_k - N_REQ;
            end
            cand_idx = IdxW'(scan_k);
            if (!win_found && bus_if.req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        opnd_d   = opnd_q;
        res_d    = res_q;
        err_d    = err_q;
        timer_d  = timer_q;
        unique case (state_q)
            StIdle: begin
                if (win_found && bus_if.conv_ready_i) begin
                    idx_d   = win_idx;
                    opnd_d  = opnd_arr[win_idx];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                // A done pulse in the final watchdog cycle still counts as success.
                if (bus_if.conv_done_i) begin
                    res_d   = bus_if.conv_bcd_i;
                    err_d   = 1'b0;
                    state_d = StRespond;
                end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = StRespond;
                end
            end
            StRespond: begin
                rr_ptr_d = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            opnd_q   <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            opnd_q   <= opnd_d;
            res_q    <= res_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
        end
    end

    assign owner_oh            = OneHotBase << idx_q;
    assign bus_if.grant_o      = (state_q != StIdle) ? owner_oh : '0;
    assign bus_if.done_o       = (state_q == StRespond) ? owner_oh : '0;
    assign bus_if.err_o        = (state_q == StRespond) && err_q;
    assign bus_if.bcd_o        = res_q;
    assign bus_if.busy_o       = (state_q != StIdle);
    assign bus_if.conv_start_o = (state_q == StIssue);
    assign bus_if.conv_bin_o   = opnd_q;

endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// Directed bench for bcd_conversion_arbiter: a converter model answers start pulses,
// expected completions are queued by the stimulus and checked by a done_o monitor.
module tb_bcd_conversion_arbiter;
    localparam int unsigned N_REQ   = 4;
    localparam int unsigned W       = 14;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned TIMEOUT = 64;

    typedef struct packed {
        logic [1:0]       idx;
        logic [BCD_W-1:0] bcd;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_ni;

    bcd_conversion_arbiter_if #(.N_REQ(N_REQ), .W(W), .BCD_W(BCD_W)) bus ();

    bcd_conversion_arbiter #(
        .N_REQ  (N_REQ),
        .W      (W),
        .BCD_W  (BCD_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .bus_if  (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   issued [N_REQ];
    int   served [N_REQ];
    bit   conv_never;
    int   conv_delay;
    int   t_start = 0;
    int   t_done = 0;
    int   stale_req_cnt = 0;
    int   stale_done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // A requester holds req_i while it still has unserved transactions.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            bus.req_i[k] = (issued[k] != served[k]);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [BCD_W-1:0] bin2bcd(input logic [W-1:0] b);
        int unsigned v;
        logic [BCD_W-1:0] r;
        v = 32'(b);
        r = '0;
        for (int d = 0; d < BCD_W / 4; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic set_bin(input int k, input logic [W-1:0] v);
        bus.bin_i[k*W +: W] = v;
    endtask

    task automatic push(input int k, input logic [BCD_W-1:0] bcd, input logic err);
        exp_t e;
        e.idx = 2'(k);
        e.bcd = bcd;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset_ni = 1'b0;
        @(posedge clk);
        #1 reset_ni = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.req_i != '0 || bus.busy_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 2000), 1);
        @(negedge clk);
    endtask

    // Converter model: answers each start after conv_delay cycles, or never.
    logic [W-1:0] model_op;
    initial begin
        bus.conv_done_i = 1'b0;
        bus.conv_bcd_i  = '0;
        forever begin
            @(negedge clk);
            if (stale_req_cnt != stale_done_cnt) begin
                stale_done_cnt++;
                @(posedge clk);
                #1;
                bus.conv_bcd_i  = 16'h4321;
                bus.conv_done_i = 1'b1;
                @(posedge clk);
                #1 bus.conv_done_i = 1'b0;
            end else if (bus.conv_start_o) begin
                t_start = cyc;
                if (!conv_never) begin
                    model_op = bus.conv_bin_o;
                    repeat (conv_delay) @(posedge clk);
                    #1;
                    t_done          = cyc;
                    bus.conv_bcd_i  = bin2bcd(model_op);
                    bus.conv_done_i = 1'b1;
                    @(posedge clk);
                    #1 bus.conv_done_i = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a completion is presented.
    logic [N_REQ-1:0] prev_done;
    logic [BCD_W-1:0] last_bcd;
    initial begin
        exp_t e;
        prev_done = '0;
        last_bcd  = '0;
        for (int k = 0; k < N_REQ; k++) served[k] = 0;
        forever begin
            @(negedge clk);
            check("grant_onehot0", 32'($countones(bus.grant_o) <= 1), 1);
            if (bus.done_o != '0) begin
                check("done_onehot", 32'($countones(bus.done_o)), 1);
                check("done_single_pulse", 32'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done_o=%b with nothing expected (t=%0t)",
                             bus.done_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", 32'(bus.done_o), 32'(N_REQ'(1) << e.idx));
                    check("grant_matches_done", 32'(bus.grant_o), 32'(bus.done_o));
                    check("bcd_o", 32'(bus.bcd_o), 32'(e.bcd));
                    check("err_o", 32'(bus.err_o), 32'(e.err));
                    if (e.err) check("timeout_latency", 32'(cyc - t_start), TIMEOUT + 1);
                    else       check("done_latency", 32'(cyc - t_done), 1);
                end
                last_bcd = bus.bcd_o;
                for (int k = 0; k < N_REQ; k++) begin
                    if (bus.done_o[k]) served[k]++;
                end
            end else if (prev_done != '0) begin
                check("bcd_hold", 32'(bus.bcd_o), 32'(last_bcd));
            end
            prev_done = bus.done_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_ni          = 1'b0;
        conv_never        = 1'b0;
        conv_delay        = 16;
        bus.conv_ready_i  = 1'b1;
        bus.bin_i         = '0;
        for (int k = 0; k < N_REQ; k++) issued[k] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(bus.grant_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_start", 32'(bus.conv_start_o), 0);
        check("rst_bcd", 32'(bus.bcd_o), 0);
        check("rst_err", 32'(bus.err_o), 0);
        check("rst_conv_bin", 32'(bus.conv_bin_o), 0);
        @(posedge clk);
        #1 reset_ni = 1'b1;

        // Single requester, start latency and operand capture.
        set_bin(0, 14'd6765);
        conv_delay = 16;
        push(0, 16'h6765, 1'b0);
        @(posedge clk);
        #1 issued[0]++;
        @(negedge clk);
        check("t1_idle_no_start", 32'(bus.conv_start_o), 0);
        @(negedge clk);
        check("t1_start", 32'(bus.conv_start_o), 1);
        check("t1_grant", 32'(bus.grant_o), 32'h1);
        check("t1_conv_bin", 32'(bus.conv_bin_o), 6765);
        set_bin(0, 14'd1);
        @(negedge clk);
        check("t1_start_pulse", 32'(bus.conv_start_o), 0);
        check("t1_bin_stable", 32'(bus.conv_bin_o), 6765);
        drain("t1");

        // Simultaneous requests from reset state: 0 then 2.
        pulse_reset();
        conv_delay = 5;
        set_bin(0, 14'd42);
        set_bin(2, 14'd610);
        push(0, 16'h0042, 1'b0);
        push(2, 16'h0610, 1'b0);
        @(posedge clk);
        #1;
        issued[0]++;
        issued[2]++;
        drain("t2");

        // Fairness with all four requesting, 0 and 1 twice; shortest converter delay.
        pulse_reset();
        conv_delay = 2;
        set_bin(0, 14'd1597);
        set_bin(1, 14'd1234);
        set_bin(2, 14'd9999);
        set_bin(3, 14'd0);
        push(0, 16'h1597, 1'b0);
        push(1, 16'h1234, 1'b0);
        push(2, 16'h9999, 1'b0);
        push(3, 16'h0000, 1'b0);
        push(0, 16'h1597, 1'b0);
        push(1, 16'h1234, 1'b0);
        @(posedge clk);
        #1;
        issued[0] += 2;
        issued[1] += 2;
        issued[2] += 1;
        issued[3] += 1;
        drain("t3");

        // Watchdog abort, then a normal transaction.
        conv_never = 1'b1;
        set_bin(1, 14'd100);
        push(1, 16'h0000, 1'b1);
        @(posedge clk);
        #1 issued[1]++;
        drain("t4_timeout");
        conv_never = 1'b0;
        conv_delay = 7;
        set_bin(1, 14'd987);
        push(1, 16'h0987, 1'b0);
        @(posedge clk);
        #1 issued[1]++;
        drain("t4_recover");

        // Done arrives in the last watchdog cycle: success wins.
        conv_delay = 64;
        set_bin(2, 14'd4181);
        push(2, 16'h4181, 1'b0);
        @(posedge clk);
        #1 issued[2]++;
        drain("t5");

        // Reset mid-WAIT abandons the transaction.
        conv_never = 1'b1;
        set_bin(3, 14'd555);
        @(posedge clk);
        #1 issued[3]++;
        repeat (10) @(negedge clk);
        check("t6_busy_in_wait", 32'(bus.busy_o), 1);
        check("t6_grant_in_wait", 32'(bus.grant_o), 32'h8);
        @(posedge clk);
        #1;
        reset_ni = 1'b0;
        issued[3]--;
        @(posedge clk);
        #1 reset_ni = 1'b1;
        @(negedge clk);
        check("t6_busy_after_rst", 32'(bus.busy_o), 0);
        check("t6_grant_after_rst", 32'(bus.grant_o), 0);
        check("t6_done_after_rst", 32'(bus.done_o), 0);
        stale_req_cnt++;
        repeat (5) begin
            @(negedge clk);
            check("t6_stale_no_done", 32'(bus.done_o), 0);
            check("t6_stale_idle", 32'(bus.busy_o), 0);
        end
        check("t6_stale_bcd", 32'(bus.bcd_o), 0);

        // conv_ready_i low holds off arbitration.
        conv_never       = 1'b0;
        conv_delay       = 4;
        bus.conv_ready_i = 1'b0;
        set_bin(3, 14'd2584);
        push(3, 16'h2584, 1'b0);
        @(posedge clk);
        #1 issued[3]++;
        repeat (6) begin
            @(negedge clk);
            check("t6_not_ready_no_start", 32'(bus.conv_start_o), 0);
            check("t6_not_ready_idle", 32'(bus.busy_o), 0);
        end
        @(posedge clk);
        #1 bus.conv_ready_i = 1'b1;
        @(negedge clk);
        check("t6_ready_still_idle", 32'(bus.conv_start_o), 0);
        @(negedge clk);
        check("t6_ready_start", 32'(bus.conv_start_o), 1);
        drain("t6_ready");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
